rx_bit_decoder: RTL
===================

// Module: rx_bit_decoder
// PURPOSE
//   Downstream consumer of the receive timer's shift_strobe. On each strobe it samples the
//   synchronized D+/D- pair, NRZI-decodes the sample and removes stuffed bits. It assembles
//   bytes LSB-first and flags end-of-packet (EOP) and stuff/line errors to the RX controller.
//   It sits between the rx_timer (bit timing) and the rx_controller (packet FSM / FIFO write).
// PARAMETERS
//   STUFF_LEN   6  consecutive decoded 1s after which the next bit must be a stuffed 0
//   EOP_SE0     2  consecutive SE0 samples that, followed by J, form a valid EOP
// PORTS
//   clk           in   1  system clock
//   rst           in   1  synchronous, active-high reset
//   dec_en        in   1  decoder enabled (rx_controller: packet in progress, after SYNC)
//   dec_clr       in   1  synchronous clear of shift/ones/NRZI state (same cycle as timer_clr)
//   shift_strobe  in   1  one-cycle pulse from rx_timer at bit centre
//   dp_sync       in   1  synchronized D+
//   dm_sync       in   1  synchronized D-
//   rx_byte       out  8  last completed byte, LSB = first bit received
//   byte_valid    out  1  one-cycle pulse: rx_byte updated
//   bit_skip      out  1  one-cycle pulse: strobed bit was a stuffed 0 and was discarded
//   eop_det       out  1  one-cycle pulse: valid EOP (EOP_SE0 x SE0 then J)
//   stuff_err     out  1  one-cycle pulse: 1 received where a stuffed 0 was required
//   line_err      out  1  one-cycle pulse: SE1 sampled, or SE0 run shorter than EOP_SE0 ends in non-SE0
// BEHAVIOUR
//   - Reset/dec_clr: all outputs and pulses 0, rx_byte=8'h00, prev_line=J, ones_cnt=0,
//     bit_cnt=0, FSM=IDLE. rst takes priority over dec_clr; dec_clr takes priority over strobe.
//   - Inputs are acted on only in a cycle where shift_strobe=1 and dec_en=1. All outputs are
//     registered and assert in the cycle after that strobe cycle (latency 1).
//   - Line state: J=(1,0) K=(0,1) SE0=(0,0) SE1=(1,1).
//   - FSM states and transitions:
//       IDLE -> ACTIVE on the first enabled strobe; that strobe is also processed as ACTIVE.
//       ACTIVE: J/K: NRZI bit = (line==prev_line); prev_line<=line.
//         * ones_cnt==STUFF_LEN: bit 0 -> bit_skip, ones_cnt<=0, no shift. Bit 1 -> stuff_err,
//           return to IDLE, partial byte dropped.
//         * otherwise shift {bit,sr[7:1]}; ones_cnt <= bit ? ones_cnt+1 : 0; bit_cnt+1.
//           The 8th bit gives rx_byte<=new sr, byte_valid pulse, bit_cnt<=0 (wraps mod 8).
//         * SE0 -> SE0_RUN with se0_cnt=1. SE1 -> line_err, IDLE.
//       SE0_RUN: SE0 -> se0_cnt+1, saturating at EOP_SE0. J with se0_cnt>=EOP_SE0 -> eop_det,
//         IDLE, prev_line=J. J with se0_cnt<EOP_SE0, or K/SE1 -> line_err, IDLE.
//   - EOP with bit_cnt!=0: eop_det still fires, the partial byte is discarded, no byte_valid.
//   - dec_en falling mid-byte: state is held (no clear) until dec_clr or the next enabled strobe.
//   - Error/EOP pulses are mutually exclusive per strobe. byte_valid and bit_skip never coincide.
//   - ones_cnt is 3 bits and bit_cnt 3 bits; no counter overflows by construction.
// STRUCTURE
//   - Package usb_rx_pkg: line_state_t {J,K,SE0,SE1} enum; decoder state_t {IDLE,ACTIVE,
//     SE0_RUN}; a function to_line(dp,dm); the constants STUFF_LEN_DEF=6 and EOP_SE0_DEF=2.
//   - One sub-module, rx_nrzi_unstuff: prev_line register, NRZI decode, ones counter. It
//     outputs bit/skip/stuff_err per strobe. The byte shifter, bit counter and FSM stay at
//     top level.
// TESTING (bench drives strobe every 8 clk, as rx_timer does)
//   1 Reset: rst=1 for 2 clk -> all pulses 0, rx_byte=00. Drive line SE0 while dec_en=0 ->
//     no outputs.
//   2 Byte 8'hA5 NRZI-encoded from prev J -> single byte_valid, rx_byte=A5, one clk after
//     the 8th strobe.
//   3 Eight 1s (no line transitions) with a stuffed K inserted after the 6th -> bit_skip on
//     the 7th strobe, byte_valid with rx_byte=FF on the 9th.
//   4 Seven consecutive 1s (no stuffed 0) -> stuff_err on the 7th strobe. The next byte
//     decodes cleanly from IDLE.
//   5 SE0,SE0,J after 2 bytes -> eop_det one clk after the J strobe. SE0,J -> line_err, no
//     eop_det.
//   6 dec_clr asserted after 3 bits of a byte, then full byte 8'h3C -> rx_byte=3C, no
//     stale bits.

Source files
------------

// File: rtl/rx_bit_decoder_pkg.sv
// Shared types and defaults for the receive-side bit decoder: line states, decoder FSM
// states and the line-pair classification helper.
package usb_rx_pkg;

  // Encoded as {dp, dm} so a sampled pair casts straight into a line state.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACTIVE  = 2'b01,
    SE0_RUN = 2'b10
  } state_t;

  localparam int STUFF_LEN_DEF = 6;
  localparam int EOP_SE0_DEF   = 2;

  function automatic line_state_t to_line(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

endpackage

// File: rtl/rx_bit_decoder_if.sv
// Signal bundle between the rx_timer/rx_controller side (master) and the bit decoder (slave).
interface rx_bit_decoder_if;
  // Strobe-qualified transfer, no backpressure: the decoder consumes dp/dm only in a cycle
  // with shift_strobe=1 and dec_en=1, and every result is a one-cycle pulse in the next cycle;
  // the master must accept each pulse when it occurs (there is no ready).
  logic       dec_en;
  logic       dec_clr;
  logic       shift_strobe;
  logic       dp_sync;
  logic       dm_sync;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       bit_skip;
  logic       eop_det;
  logic       stuff_err;
  logic       line_err;

  modport master (
    output dec_en, dec_clr, shift_strobe, dp_sync, dm_sync,
    input  rx_byte, byte_valid, bit_skip, eop_det, stuff_err, line_err
  );

  modport slave (
    input  dec_en, dec_clr, shift_strobe, dp_sync, dm_sync,
    output rx_byte, byte_valid, bit_skip, eop_det, stuff_err, line_err
  );
endinterface

// File: rtl/rx_bit_decoder_nrzi_unstuff.sv
// NRZI decode and bit-stuff removal: tracks the previous J/K level and the run of decoded 1s.
// Results are combinational for the current step; the top registers them.
module rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        step,
  input  line_state_t line,
  input  logic        restart,
  input  logic        set_j,
  output logic        bit_val,
  output logic        skip,
  output logic        stuff_err
);

  line_state_t prev_line;
  logic [2:0]  ones_cnt;
  logic        at_limit;

  assign bit_val   = (line == prev_line);
  assign at_limit  = (ones_cnt == 3'(STUFF_LEN));
  assign skip      = step & at_limit & ~bit_val;
  assign stuff_err = step & at_limit & bit_val;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_line <= LINE_J;
      ones_cnt  <= 3'd0;
    end else begin
      if (step) begin
        prev_line <= line;
        // A stuffed 0 or a stuff violation both end the run of ones.
        if (at_limit || !bit_val) ones_cnt <= 3'd0;
        else                      ones_cnt <= ones_cnt + 3'd1;
      end
      if (restart) ones_cnt  <= 3'd0;
      if (set_j)   prev_line <= LINE_J;
    end
  end

endmodule

// File: rtl/rx_bit_decoder.sv
// Receive bit decoder: samples the line on each enabled strobe, assembles LSB-first bytes
// and reports byte, stuffed-bit, EOP and error events one cycle after the strobe.
module rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int EOP_SE0   = EOP_SE0_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rx_bit_decoder_if.slave   bus,
  output state_t            dbg_state
);

  localparam int SE0_W = $clog2(EOP_SE0 + 1);

  state_t             state, state_n;
  logic [7:0]         sr, sr_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [SE0_W-1:0]   se0_cnt, se0_n;
  logic [7:0]         rx_byte_n;
  logic               byte_valid_n, bit_skip_n, eop_det_n, stuff_err_n, line_err_n;

  logic               st;
  line_state_t        line;
  logic               is_jk;
  logic               step;
  logic               restart;
  logic               set_j;
  logic               bit_val;
  logic               skip_w;
  logic               stuff_err_w;

  assign st    = bus.shift_strobe & bus.dec_en;
  assign line  = to_line(bus.dp_sync, bus.dm_sync);
  assign is_jk = (line == LINE_J) || (line == LINE_K);
  // IDLE handles its first strobe exactly like ACTIVE.
  assign step  = st & is_jk & (state != SE0_RUN);

  assign dbg_state = state;

  rx_nrzi_unstuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.dec_clr),
    .step      (step),
    .line      (line),
    .restart   (restart),
    .set_j     (set_j),
    .bit_val   (bit_val),
    .skip      (skip_w),
    .stuff_err (stuff_err_w)
  );

  always_comb begin
    state_n      = state;
    sr_n         = sr;
    bit_cnt_n    = bit_cnt;
    se0_n        = se0_cnt;
    rx_byte_n    = bus.rx_byte;
    byte_valid_n = 1'b0;
    bit_skip_n   = 1'b0;
    eop_det_n    = 1'b0;
    stuff_err_n  = 1'b0;
    line_err_n   = 1'b0;
    restart      = 1'b0;
    set_j        = 1'b0;

    if (st) begin
      case (state)
        IDLE, ACTIVE: begin
          state_n = ACTIVE;
          unique case (line)
            LINE_J, LINE_K: begin
              if (stuff_err_w) begin
                stuff_err_n = 1'b1;
                state_n     = IDLE;
                bit_cnt_n   = 3'd0;
              end else if (skip_w) begin
                bit_skip_n = 1'b1;
              end else begin
                sr_n      = {bit_val, sr[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  rx_byte_n    = {bit_val, sr[7:1]};
                  byte_valid_n = 1'b1;
                end
              end
            end
            LINE_SE0: begin
              state_n = SE0_RUN;
              se0_n   = SE0_W'(1);
            end
            LINE_SE1: begin
              line_err_n = 1'b1;
              state_n    = IDLE;
              bit_cnt_n  = 3'd0;
              restart    = 1'b1;
            end
          endcase
        end
        SE0_RUN: begin
          if (line == LINE_SE0) begin
            if (se0_cnt != SE0_W'(EOP_SE0)) se0_n = se0_cnt + SE0_W'(1);
          end else begin
            // Any non-SE0 sample ends the run; only a long enough run closed by J is an EOP.
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            restart   = 1'b1;
            if (line == LINE_J && se0_cnt >= SE0_W'(EOP_SE0)) begin
              eop_det_n = 1'b1;
              set_j     = 1'b1;
            end else begin
              line_err_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.dec_clr) begin
      state          <= IDLE;
      sr             <= 8'h00;
      bit_cnt        <= 3'd0;
      se0_cnt        <= '0;
      bus.rx_byte    <= 8'h00;
      bus.byte_valid <= 1'b0;
      bus.bit_skip   <= 1'b0;
      bus.eop_det    <= 1'b0;
      bus.stuff_err  <= 1'b0;
      bus.line_err   <= 1'b0;
    end else begin
      state          <= state_n;
      sr             <= sr_n;
      bit_cnt        <= bit_cnt_n;
      se0_cnt        <= se0_n;
      bus.rx_byte    <= rx_byte_n;
      bus.byte_valid <= byte_valid_n;
      bus.bit_skip   <= bit_skip_n;
      bus.eop_det    <= eop_det_n;
      bus.stuff_err  <= stuff_err_n;
      bus.line_err   <= line_err_n;
    end
  end

endmodule
